// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file.
package regfile_pkg;
    localparam int          XLEN_DEF   = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int          REG_NUM    = 32;
    localparam logic [31:0] ZERO_WORD  = 32'h0;
    localparam logic [4:0]  REG_X0     = 5'd0;

    // True when an index names the hard-wired zero register.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
        return a == REG_X0;
    endfunction
endpackage

// File: rtl/regfile_if.sv
// Write port from execute, two read ports to decode, and a debug read port.
interface regfile_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] rd_addr_i;
    logic [XLEN-1:0]   rd_data_i;
    logic              rd_wen_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [XLEN-1:0]   rs1_data_o;
    logic [XLEN-1:0]   rs2_data_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [XLEN-1:0]   dbg_data_o;

    // Pipeline side: drives indices and write data, consumes read data.
    modport master (
        output rd_addr_i, rd_data_i, rd_wen_i, rs1_addr_i, rs2_addr_i, dbg_addr_i,
        input  rs1_data_o, rs2_data_o, dbg_data_o
    );

    // Register file side.
    modport slave (
        input  rd_addr_i, rd_data_i, rd_wen_i, rs1_addr_i, rs2_addr_i, dbg_addr_i,
        output rs1_data_o, rs2_data_o, dbg_data_o
    );
endinterface

// File: rtl/regfile_rport.sv
// Combinational read-port selector: x0 forces zero, then write-first bypass,
// then the stored value. Tie i_byp_en low for a storage-only view.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = regfile_pkg::REG_NUM
) (
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           i_byp_en,
    input  logic [ADDR_W-1:0]              i_wr_addr,
    input  logic [XLEN-1:0]                i_wr_data,
    input  logic [REG_NUM-1:0][XLEN-1:0]   i_regs,
    output logic [XLEN-1:0]                o_data
);
    // Priority select: zero register, then in-flight write, then storage.
    always_comb begin
        o_data = i_regs[i_addr];
        if (i_addr == '0)
            o_data = XLEN'(ZERO_WORD);
        else if (i_byp_en && (i_wr_addr == i_addr))
            o_data = i_wr_data;
    end
endmodule

// File: rtl/regfile.sv
// RV32I integer register file: x1..x31 in flops, x0 hard-wired to zero,
// two combinational write-first read ports and a registered debug port.
module regfile
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_NUM = regfile_pkg::REG_NUM,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);
    logic [XLEN-1:0]                 r_regs [1:REG_NUM-1];
    logic [REG_NUM-1:0][XLEN-1:0]    w_regs;
    logic [XLEN-1:0]                 w_dbg;
    logic [XLEN-1:0]                 r_dbg;
    logic [XLEN-1:0]                 w_rs1;
    logic [XLEN-1:0]                 w_rs2;

    // No storage behind index 0; the flat view just shows zero there.
    assign w_regs[0] = '0;

    for (genvar g = 1; g < REG_NUM; g++) begin : g_reg
        // Each register captures the write data when it is the write target; reset wins.
        always_ff @(posedge clk) begin
            if (rst)
                r_regs[g] <= '0;
            else if (bus.rd_wen_i && (bus.rd_addr_i == ADDR_W'(g)))
                r_regs[g] <= bus.rd_data_i;
        end
        assign w_regs[g] = r_regs[g];
    end

    regfile_rport #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_rs1 (
        .i_addr    (bus.rs1_addr_i),
        .i_byp_en  (bus.rd_wen_i),
        .i_wr_addr (bus.rd_addr_i),
        .i_wr_data (bus.rd_data_i),
        .i_regs    (w_regs),
        .o_data    (w_rs1)
    );

    regfile_rport #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_rs2 (
        .i_addr    (bus.rs2_addr_i),
        .i_byp_en  (bus.rd_wen_i),
        .i_wr_addr (bus.rd_addr_i),
        .i_wr_data (bus.rd_data_i),
        .i_regs    (w_regs),
        .o_data    (w_rs2)
    );

    // Debug sees committed state only, so the bypass is held off.
    regfile_rport #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_dbg (
        .i_addr    (bus.dbg_addr_i),
        .i_byp_en  (1'b0),
        .i_wr_addr (bus.rd_addr_i),
        .i_wr_data (bus.rd_data_i),
        .i_regs    (w_regs),
        .o_data    (w_dbg)
    );

    // One-cycle registered debug read.
    always_ff @(posedge clk) begin
        if (rst)
            r_dbg <= '0;
        else
            r_dbg <= w_dbg;
    end

    assign bus.rs1_data_o = w_rs1;
    assign bus.rs2_data_o = w_rs2;
    assign bus.dbg_data_o = r_dbg;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_regfile;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] model [32];
    logic [31:0] dbg_exp;

    regfile_if #(.XLEN(32), .ADDR_W(5)) bus ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Architectural read: zero register, pending write, or stored value.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.rd_wen_i && bus.rd_addr_i == a) return bus.rd_data_i;
        return model[a];
    endfunction

    // Advance the model by one edge with the current inputs, then clock the DUT.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            dbg_exp = 32'h0;
        end else begin
            dbg_exp = (bus.dbg_addr_i == 5'd0) ? 32'h0 : model[bus.dbg_addr_i];
            if (bus.rd_wen_i && bus.rd_addr_i != 5'd0) model[bus.rd_addr_i] = bus.rd_data_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rd_wen_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr_i = 5'(a);
            bus.rs2_addr_i = 5'(31 - a);
            bus.dbg_addr_i = 5'(a);
            #1;
            checks += 2;
            if (bus.rs1_data_o !== 32'h0) begin
                failures++; $display("FAIL reset_rs1 x%0d got=%h exp=0", a, bus.rs1_data_o);
            end
            if (bus.rs2_data_o !== 32'h0) begin
                failures++; $display("FAIL reset_rs2 x%0d got=%h exp=0", 31 - a, bus.rs2_data_o);
            end
            step();
            checks++;
            if (bus.dbg_data_o !== 32'h0) begin
                failures++; $display("FAIL reset_dbg x%0d got=%h exp=0", a, bus.dbg_data_o);
            end
        end
    endtask

    task automatic test_basic();
        bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd5; bus.rd_data_i = 32'hDEADBEEF;
        step();
        bus.rd_wen_i = 1'b0; bus.rs1_addr_i = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL basic_x5 got=%h exp=deadbeef", bus.rs1_data_o);
        end
        bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd31; bus.rd_data_i = 32'hFFFFFFFF;
        step();
        bus.rd_wen_i = 1'b0; bus.rs2_addr_i = 5'd31;
        #1;
        checks++;
        if (bus.rs2_data_o !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL basic_x31 got=%h exp=ffffffff", bus.rs2_data_o);
        end
    endtask

    task automatic test_x0();
        bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd0; bus.rd_data_i = 32'h12345678;
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd0; bus.dbg_addr_i = 5'd0;
        #1;
        checks += 2;
        if (bus.rs1_data_o !== 32'h0) begin
            failures++; $display("FAIL x0_same_rs1 got=%h exp=0", bus.rs1_data_o);
        end
        if (bus.rs2_data_o !== 32'h0) begin
            failures++; $display("FAIL x0_same_rs2 got=%h exp=0", bus.rs2_data_o);
        end
        step();
        bus.rd_wen_i = 1'b0;
        step();
        #1;
        checks += 3;
        if (bus.rs1_data_o !== 32'h0) begin
            failures++; $display("FAIL x0_after_rs1 got=%h exp=0", bus.rs1_data_o);
        end
        if (bus.rs2_data_o !== 32'h0) begin
            failures++; $display("FAIL x0_after_rs2 got=%h exp=0", bus.rs2_data_o);
        end
        if (bus.dbg_data_o !== 32'h0) begin
            failures++; $display("FAIL x0_dbg got=%h exp=0", bus.dbg_data_o);
        end
    endtask

    task automatic test_bypass();
        bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd7; bus.rd_data_i = 32'h11112222;
        bus.dbg_addr_i = 5'd7;
        step();
        bus.rd_data_i = 32'hA5A5A5A5;
        bus.rs1_addr_i = 5'd7; bus.rs2_addr_i = 5'd7;
        #1;
        checks += 2;
        if (bus.rs1_data_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL bypass_rs1 got=%h exp=a5a5a5a5", bus.rs1_data_o);
        end
        if (bus.rs2_data_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL bypass_rs2 got=%h exp=a5a5a5a5", bus.rs2_data_o);
        end
        step();
        checks++;
        if (bus.dbg_data_o !== 32'h11112222) begin
            failures++; $display("FAIL bypass_dbg_old got=%h exp=11112222", bus.dbg_data_o);
        end
        bus.rd_wen_i = 1'b0; bus.rd_data_i = 32'hFFFF0000;
        #1;
        checks += 2;
        if (bus.rs1_data_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL nobypass_rs1 got=%h exp=a5a5a5a5", bus.rs1_data_o);
        end
        if (bus.rs2_data_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL nobypass_rs2 got=%h exp=a5a5a5a5", bus.rs2_data_o);
        end
        step();
        checks++;
        if (bus.dbg_data_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL bypass_dbg_new got=%h exp=a5a5a5a5", bus.dbg_data_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.rs1_addr_i = 5'd3; bus.rs2_addr_i = 5'd3; bus.dbg_addr_i = 5'd3;
        for (int v = 1; v <= 3; v++) begin
            bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd3; bus.rd_data_i = 32'(v);
            #1;
            checks++;
            if (bus.rs1_data_o !== 32'(v)) begin
                failures++; $display("FAIL b2b_bypass v=%0d got=%h", v, bus.rs1_data_o);
            end
            step();
        end
        bus.rd_wen_i = 1'b0;
        #1;
        checks += 2;
        if (bus.rs2_data_o !== 32'd3) begin
            failures++; $display("FAIL b2b_stored got=%h exp=3", bus.rs2_data_o);
        end
        step();
        if (bus.dbg_data_o !== 32'd3) begin
            failures++; $display("FAIL b2b_dbg got=%h exp=3", bus.dbg_data_o);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        bus.rd_wen_i = 1'b1; bus.rd_addr_i = 5'd10; bus.rd_data_i = 32'h55;
        bus.rs1_addr_i = 5'd10; bus.rs2_addr_i = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data_o !== 32'h55) begin
            failures++; $display("FAIL rstmid_bypass got=%h exp=55", bus.rs1_data_o);
        end
        step();
        rst = 1'b0; bus.rd_wen_i = 1'b0;
        #1;
        checks += 2;
        if (bus.rs1_data_o !== 32'h0) begin
            failures++; $display("FAIL rstmid_x10 got=%h exp=0", bus.rs1_data_o);
        end
        if (bus.rs2_data_o !== 32'h0) begin
            failures++; $display("FAIL rstmid_x5 got=%h exp=0", bus.rs2_data_o);
        end
        bus.rd_wen_i = 1'b1; bus.rd_data_i = 32'h66;
        step();
        bus.rd_wen_i = 1'b0;
        #1;
        checks++;
        if (bus.rs1_data_o !== 32'h66) begin
            failures++; $display("FAIL rstmid_rewrite got=%h exp=66", bus.rs1_data_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.rd_wen_i   = 1'($urandom_range(0, 1));
            bus.rd_addr_i  = 5'($urandom_range(0, 31));
            bus.rd_data_i  = $urandom;
            bus.rs1_addr_i = ($urandom_range(0, 3) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31));
            bus.rs2_addr_i = ($urandom_range(0, 3) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31));
            bus.dbg_addr_i = 5'($urandom_range(0, 31));
            #1;
            e1 = exp_read(bus.rs1_addr_i);
            e2 = exp_read(bus.rs2_addr_i);
            checks += 2;
            if (bus.rs1_data_o !== e1) begin
                failures++; $display("FAIL rand_rs1 n=%0d x%0d got=%h exp=%h", n, bus.rs1_addr_i, bus.rs1_data_o, e1);
            end
            if (bus.rs2_data_o !== e2) begin
                failures++; $display("FAIL rand_rs2 n=%0d x%0d got=%h exp=%h", n, bus.rs2_addr_i, bus.rs2_data_o, e2);
            end
            step();
            checks++;
            if (bus.dbg_data_o !== dbg_exp) begin
                failures++; $display("FAIL rand_dbg n=%0d got=%h exp=%h", n, bus.dbg_data_o, dbg_exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        dbg_exp = 32'h0;
        rst = 1'b1;
        bus.rd_wen_i = 1'b0; bus.rd_addr_i = 5'd0; bus.rd_data_i = 32'h0;
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd0; bus.dbg_addr_i = 5'd0;
        #1;
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

Integer register file for the RV32I pipeline: 32 × 32-bit architectural registers (x0–x31). It is the write-side endpoint of the execute stage's `rd_addr/rd_data/rd_wen` interface and the read-side source for the decode stage's two operand fetches. It provides write-first bypass, so an operand read in the same cycle as a write to that register returns the new value. Register x0 always reads zero and is never written.

## Interface
Parameters:
- `XLEN`, 32: register width.
- `REG_NUM`, 32: number of architectural registers.
- `ADDR_W`, 5: register index width; `2**ADDR_W == REG_NUM`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `rd_addr_i`, in, ADDR_W: write index from execute.
- `rd_data_i`, in, XLEN: write data from execute.
- `rd_wen_i`, in, 1: write enable from execute.
- `rs1_addr_i`, in, ADDR_W: read port 1 index from decode.
- `rs2_addr_i`, in, ADDR_W: read port 2 index from decode.
- `rs1_data_o`, out, XLEN: read port 1 data; combinational.
- `rs2_data_o`, out, XLEN: read port 2 data; combinational.
- `dbg_addr_i`, in, ADDR_W: debug/testbench inspection index.
- `dbg_data_o`, out, XLEN: registered debug read; one cycle latency.

## Operation
- Storage: array `regs[1..REG_NUM-1]`. There is no physical x0 storage.
- Write: on the rising edge, if `rd_wen_i && rd_addr_i != 0`, then `regs[rd_addr_i] <= rd_data_i`. A write to x0 is silently dropped. When `rd_wen_i` is low, `rd_addr_i` and `rd_data_i` are don't-care.
- Read port N, priority order:
  - `rsN_addr_i == 0` → 0.
  - Else if `rd_wen_i && rd_addr_i == rsN_addr_i` → `rd_data_i` (bypass).
  - Else → `regs[rsN_addr_i]`.
- Both read ports are independent. Both may address the same register, and both may hit the bypass at once.
- Debug port: `dbg_data_o <= (dbg_addr_i == 0) ? 0 : regs[dbg_addr_i]`. It reads stored state only, with no bypass, so it shows state after prior edges.
- No arithmetic is performed. Data passes through at full XLEN width with no sign or zero extension.

## Timing
- Reset: while `rst` is high at an edge, all `regs` entries and `dbg_data_o` are cleared to 0, and any write in that cycle is ignored (reset wins).
- While `rst` is asserted, the read ports still follow the priority rules above: stored values read 0 after the first reset edge, and the bypass remains active.
- Write-to-storage latency: 1 edge. A value written at edge N is readable from storage from cycle N onward, and visible the same cycle via bypass.
- Read latency: 0 cycles, combinational from address/write inputs.
- Debug latency: 1 cycle.
- Simultaneous write and read of the same register: the read returns the new data (write-first).
- Writes in consecutive cycles to the same register: the last write wins. There is no queueing.
- Reset asserted mid-stream: a pending write in that cycle is lost. Software-visible state restarts at all zeros.

## Structure
- Shared `defines.v` (already included by core stages) gains:
  - `ZERO_WORD` (32'h0)
  - `REG_ADDR_W` (5)
  - `REG_NUM` (32)
  - `REG_X0` (5'd0)
- Parameters above default to these macros.
- One natural sub-module: `regfile_rport`, a combinational read-port selector (x0 check, bypass compare, array select). It is instantiated twice, for rs1 and rs2. The debug port reuses its x0 check with the bypass disabled.
- Execute drives the write port directly. No handshake is required because `rd_wen_i` is a single-cycle qualifier.

## Test plan
- Reset: hold `rst` for 2 cycles, then read all 32 indices on rs1 and rs2 → every read returns 0 and `dbg_data_o` = 0.
- Basic write/read:
  - Write x5 = 0xDEADBEEF; next cycle `rs1_addr_i=5` → 0xDEADBEEF.
  - Write x31 = 0xFFFFFFFF; `rs2_addr_i=31` → 0xFFFFFFFF.
- x0 protection: write x0 = 0x12345678 with `rd_wen_i=1`, then read x0 on both ports and debug → 0 in the same cycle and after.
- Bypass:
  - Same cycle: write x7 = 0xA5A5A5A5 while `rs1_addr_i=rs2_addr_i=7` → both outputs 0xA5A5A5A5 that cycle; debug (`dbg_addr_i=7`) shows the old value, then 0xA5A5A5A5 one cycle after the edge.
  - Disabled: repeat with `rd_wen_i=0` → old value returned.
- Back-to-back same register: write x3 = 1, then 2, then 3 on consecutive edges while reading x3 → 1, 2, 3 via bypass each cycle; storage holds 3.
- Reset mid-operation: write x10 = 0x55 in the same cycle `rst=1` → x10 reads 0 afterward; a subsequent write without reset succeeds.
